// File: rtl/output_rr_arbiter_pkg.sv
// Shared types and defaults for the output-port round-robin arbiter.
package output_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE          = 2'd0,
        S_XFER          = 2'd1,
        S_WAIT_LAST_ACK = 2'd2
    } arb_state_e;

    localparam int unsigned DEFAULT_NUMBER_CHANNELS = 5;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 1024;

endpackage

// File: rtl/output_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request searching upward
// from (ptr+1) mod N, wrapping. Returns one-hot winner and its index.
module rr_pick #(
    parameter int unsigned N  = 5,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IW'((32'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                win_idx   = cand;
                win[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_rr_arbiter.sv
// Round-robin packet arbiter for one switch output; locks the winner until the
// eop/ack handshake. Define OUTPUT_ARB_TIMEOUT_EN to add the stall watchdog.
module output_rr_arbiter
    import output_arb_pkg::*;
#(
    parameter int unsigned NUMBER_CHANNELS = DEFAULT_NUMBER_CHANNELS,
    parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUMBER_CHANNELS-1:0] req_channel,
    input  logic                       ack,
    input  logic                       eop,
    output logic [NUMBER_CHANNELS-1:0] gnt_channel,
    output logic [NUMBER_CHANNELS-1:0] sel_channel,
    output logic                       idle,
    output logic                       timeout_err
);

    localparam int unsigned IW = (NUMBER_CHANNELS > 1) ? $clog2(NUMBER_CHANNELS) : 1;

    if (NUMBER_CHANNELS < 2) begin : g_bad_channels
        $error("NUMBER_CHANNELS must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_e                 state_q, state_d;
    logic [IW-1:0]              ptr_q, ptr_d;
    logic [NUMBER_CHANNELS-1:0] gnt_q, gnt_d;
    logic [NUMBER_CHANNELS-1:0] sel_q, sel_d;
    logic [NUMBER_CHANNELS-1:0] win;
    logic [IW-1:0]              win_idx;
    logic                       any_req;

    rr_pick #(
        .N  (NUMBER_CHANNELS),
        .IW (IW)
    ) u_pick (
        .req     (req_channel),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx),
        .any     (any_req)
    );

`ifdef OUTPUT_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_XFER;
                    gnt_d   = win;
                    sel_d   = win;
                    ptr_d   = win_idx;
                end
            end
            S_XFER: begin
                if (eop && ack) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    sel_d   = '0;
                end else if (eop) begin
                    // sel stays so the pending last beat remains routed
                    state_d = S_WAIT_LAST_ACK;
                    gnt_d   = '0;
                end
            end
            S_WAIT_LAST_ACK: begin
                if (ack) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    sel_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                sel_d   = '0;
            end
        endcase

`ifdef OUTPUT_ARB_TIMEOUT_EN
        cnt_d = cnt_q;
        tmo_d = 1'b0;
        if (state_q == S_IDLE || ack) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            // ptr keeps the offender so it drops to lowest priority
            state_d = S_IDLE;
            gnt_d   = '0;
            sel_d   = '0;
            tmo_d   = 1'b1;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= IW'(NUMBER_CHANNELS - 1);
            gnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
        end
    end

`ifdef OUTPUT_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign gnt_channel = gnt_q;
    assign sel_channel = sel_q;
    assign idle        = (state_q == S_IDLE);

endmodule

// File: tb/tb_output_rr_arbiter.sv
// Self-checking bench for output_rr_arbiter: directed scenarios plus random
// traffic against a packet-level reference model.
module tb_output_rr_arbiter;

    localparam int N = 5;
`ifdef OUTPUT_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1024;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req_channel = '0;
    logic         ack = 1'b0;
    logic         eop = 1'b0;
    logic [N-1:0] gnt_channel;
    logic [N-1:0] sel_channel;
    logic         idle;
    logic         timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    output_rr_arbiter #(
        .NUMBER_CHANNELS (N),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_channel (req_channel),
        .ack         (ack),
        .eop         (eop),
        .gnt_channel (gnt_channel),
        .sel_channel (sel_channel),
        .idle        (idle),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Packet-level reference: owner = channel holding the port (-1 when free).
    int m_owner;
    bit m_wait;
    int m_ptr;
    bit m_tmo;
    int m_stall;

    function automatic int rr_winner(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (((r >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_wait  = 0;
        m_ptr   = N - 1;
        m_tmo   = 0;
        m_stall = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input bit a, input bit e);
        m_tmo = 0;
        if (m_owner < 0) begin
            int w;
            w = rr_winner(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = w;
                m_wait  = 0;
                m_stall = 0;
            end
        end else begin
`ifdef OUTPUT_ARB_TIMEOUT_EN
            if (!a && m_stall == TMO - 1) begin
                m_owner = -1;
                m_tmo   = 1;
                return;
            end
            m_stall = a ? 0 : m_stall + 1;
`endif
            if (!m_wait) begin
                if (e && a) m_owner = -1;
                else if (e) m_wait = 1;
            end else if (a) begin
                m_owner = -1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_channel = '0;
        ack = 1'b0;
        eop = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_cmp++; if (gnt_channel !== 5'b00000) begin n_err++; $display("FAIL reset_gnt: got %b want 00000", gnt_channel); end
        n_cmp++; if (sel_channel !== 5'b00000) begin n_err++; $display("FAIL reset_sel: got %b want 00000", sel_channel); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", idle); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_packet();
        do_reset();
        req_channel = 5'b00001; ack = 1'b1; eop = 1'b0;
        tick();
        n_cmp++; if (gnt_channel !== 5'b00001) begin n_err++; $display("FAIL single_gnt: got %b want 00001", gnt_channel); end
        n_cmp++; if (sel_channel !== 5'b00001) begin n_err++; $display("FAIL single_sel: got %b want 00001", sel_channel); end
        n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b want 0", idle); end
        for (int b = 0; b < 2; b++) begin
            tick();
            n_cmp++; if (gnt_channel !== 5'b00001) begin n_err++; $display("FAIL single_hold%0d: got %b want 00001", b, gnt_channel); end
        end
        eop = 1'b1;
        tick();
        n_cmp++; if (idle !== 1'b1 || gnt_channel !== 5'b00000) begin n_err++; $display("FAIL single_end: got idle=%b gnt=%b want idle=1 gnt=00000", idle, gnt_channel); end
        eop = 1'b0;
        tick();
        n_cmp++; if (idle !== 1'b0 || gnt_channel !== 5'b00001) begin n_err++; $display("FAIL single_one_idle: got idle=%b gnt=%b want idle=0 gnt=00001", idle, gnt_channel); end
        req_channel = '0; eop = 1'b1;
        tick();
        eop = 1'b0; ack = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        do_reset();
        req_channel = 5'b11111; ack = 1'b1; eop = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp = '0;
            exp[i % N] = 1'b1;
            tick();
            n_cmp++; if (gnt_channel !== exp) begin n_err++; $display("FAIL rr_order%0d: got %b want %b", i, gnt_channel, exp); end
            tick();
            n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rr_idle%0d: got %b want 1", i, idle); end
        end
        req_channel = '0; ack = 1'b0; eop = 1'b0;
        tick();
    endtask

    task automatic test_wait_last_ack();
        do_reset();
        req_channel = 5'b00100;
        tick();
        n_cmp++; if (gnt_channel !== 5'b00100) begin n_err++; $display("FAIL wait_gnt: got %b want 00100", gnt_channel); end
        req_channel = '0; eop = 1'b1; ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (gnt_channel !== 5'b00000 || sel_channel !== 5'b00100 || idle !== 1'b0) begin
                n_err++; $display("FAIL wait_hold%0d: got gnt=%b sel=%b idle=%b want gnt=00000 sel=00100 idle=0", c, gnt_channel, sel_channel, idle);
            end
        end
        ack = 1'b1;
        tick();
        n_cmp++; if (idle !== 1'b1 || sel_channel !== 5'b00000) begin n_err++; $display("FAIL wait_release: got idle=%b sel=%b want idle=1 sel=00000", idle, sel_channel); end
        ack = 1'b0; eop = 1'b0;
    endtask

    task automatic test_packet_lock();
        do_reset();
        req_channel = 5'b00010;
        tick();
        req_channel = 5'b01000; ack = 1'b1; eop = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (gnt_channel !== 5'b00010) begin n_err++; $display("FAIL lock_hold%0d: got %b want 00010", c, gnt_channel); end
        end
        eop = 1'b1;
        tick();
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL lock_idle: got %b want 1", idle); end
        eop = 1'b0;
        tick();
        n_cmp++; if (gnt_channel !== 5'b01000) begin n_err++; $display("FAIL lock_next: got %b want 01000", gnt_channel); end
        req_channel = '0; eop = 1'b1;
        tick();
        eop = 1'b0; ack = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_channel = 5'b00100;
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (gnt_channel !== 5'b00000 || sel_channel !== 5'b00000 || idle !== 1'b1) begin
            n_err++; $display("FAIL async_rst: got gnt=%b sel=%b idle=%b want gnt=00000 sel=00000 idle=1", gnt_channel, sel_channel, idle);
        end
        #1 rst = 1'b0;
        req_channel = 5'b10001;
        tick();
        n_cmp++; if (gnt_channel !== 5'b00001) begin n_err++; $display("FAIL async_rearb: got %b want 00001", gnt_channel); end
        req_channel = '0; ack = 1'b1; eop = 1'b1;
        tick();
        ack = 1'b0; eop = 1'b0;
    endtask

`ifdef OUTPUT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req_channel = 5'b00001;
        tick();
        req_channel = 5'b00011;
        for (int c = 0; c < TMO - 1; c++) begin
            tick();
            n_cmp++; if (timeout_err !== 1'b0 || gnt_channel !== 5'b00001) begin
                n_err++; $display("FAIL tmo_stall%0d: got tmo=%b gnt=%b want tmo=0 gnt=00001", c, timeout_err, gnt_channel);
            end
        end
        tick();
        n_cmp++; if (timeout_err !== 1'b1 || gnt_channel !== 5'b00000 || idle !== 1'b1) begin
            n_err++; $display("FAIL tmo_fire: got tmo=%b gnt=%b idle=%b want tmo=1 gnt=00000 idle=1", timeout_err, gnt_channel, idle);
        end
        tick();
        n_cmp++; if (timeout_err !== 1'b0 || gnt_channel !== 5'b00010) begin
            n_err++; $display("FAIL tmo_next: got tmo=%b gnt=%b want tmo=0 gnt=00010", timeout_err, gnt_channel);
        end
        req_channel = '0; ack = 1'b1; eop = 1'b1;
        tick();
        ack = 1'b0; eop = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] exp_gnt, exp_sel;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_channel = N'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            eop = ($urandom_range(0, 2) == 0);
            model_edge(req_channel, ack, eop);
            tick();
            exp_gnt = '0;
            exp_sel = '0;
            if (m_owner >= 0) begin
                exp_sel[m_owner] = 1'b1;
                if (!m_wait) exp_gnt[m_owner] = 1'b1;
            end
            n_cmp++;
            if (gnt_channel !== exp_gnt || sel_channel !== exp_sel || idle !== (m_owner < 0) || timeout_err !== m_tmo) begin
                n_err++;
                $display("FAIL random_c%0d: got gnt=%b sel=%b idle=%b tmo=%b want gnt=%b sel=%b idle=%b tmo=%b",
                         c, gnt_channel, sel_channel, idle, timeout_err, exp_gnt, exp_sel, (m_owner < 0), m_tmo);
            end
        end
        req_channel = '0; ack = 1'b0; eop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_wait_last_ack();
        test_packet_lock();
        test_async_reset();
`ifdef OUTPUT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
